alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//   Parametrised, sequencing successor of the ALU controller. Decodes ALUop/functionCode/Shamt into the same 6-bit ALUctrl codes.
//   Shifts by any amount are split into a sequence of shift-by-8/2/1 ALU operations. MULTU is held for a configurable cycle count.
//   Sits between ID/EX decode and the ALU. Drives a stall to the pipeline and an operand-feedback select to the ALU.
// PARAMETERS
//   SHAMT_W      5   width of Shamt; supports shift amounts 0..2^SHAMT_W-1
//   MULT_CYCLES  4   cycles ALUctrl='h13 is held for MULTU (>=1)
// PORTS
//   clk           in   1        clock, rising edge
//   reset         in   1        synchronous, active-high reset
//   start         in   1        decoded instruction valid; sampled only in IDLE
//   ALUop         in   5        main-control ALU operation
//   functionCode  in   6        R-type funct field
//   Shamt         in   SHAMT_W  shift amount
//   ALUctrl       out  6        registered ALU operation code
//   feedback      out  1        1: ALU operand A = previous ALU result (chained shift step)
//   stall         out  1        1: pipeline must hold; more steps follow this cycle
//   done          out  1        1-cycle pulse on the last (or only) step
// BEHAVIOUR
// - All outputs registered. Reset (any state, mid-sequence included) forces IDLE, ALUctrl=0, feedback=0, stall=0, done=0 next edge.
// - Code map unchanged:
//     ALUop 0->'h2, 1->'h6, 3..9 -> 'h3,'h0,'h1,'h4,'h7,'h8,'h9; other ALUop -> 'h0.
//     ALUop 2 (R-type) funct: 20->2, 21->3, 23->6, 24->0, 25->1, 26->4, 2A->7, 2B->8, 10/12->0, 19->'h13; other funct -> 'h0.
//     Shift-step codes: SLL 8/2/1 = C/B/A; SRL 8/2/1 = F/E/D; SRA 8/2/1 = 12/11/10.
// - FSM states IDLE, SHIFT, MULT. start is accepted only in IDLE; start in SHIFT/MULT is ignored.
//     Legal use: the pipeline holds start and inputs stable while stall=1.
// - Accept at edge k; the first output step is visible in cycle k+1 (latency 1).
// - IDLE, no start: outputs 0.
// - Single-cycle op (non-shift, non-MULTU; also a shift with Shamt=0): ALUctrl=code, done=1, stall=0, feedback=0 for one cycle.
//     Back-to-back accepts are allowed (next start is sampled in the same edge as done).
//     Shamt=0 shift emits 'h0, unchanged from current behaviour.
// - SHIFT: captured at accept.
//     n8 = Shamt>>3, n2 = Shamt[2:1], n1 = Shamt[0]; N = n8+n2+n1 steps.
//     Step order: all 8-steps, then 2-steps, then the 1-step.
//     Step 1: feedback=0. Steps 2..N: feedback=1.
//     stall=1 on steps 1..N-1; step N: stall=0, done=1. Then IDLE (or a new accept).
//     Counters are sized from SHAMT_W (n8 is SHAMT_W-3 bits). No wrap for any Shamt value.
// - MULT: ALUctrl='h13 for MULT_CYCLES cycles, feedback=0.
//     stall=1 except the last cycle; done=1 on the last cycle.
//     MULT_CYCLES=1 behaves as a single-cycle op.
// - stall and done are never both 1. done=1 implies the FSM can accept in the same edge.
// TESTING
//   1 ALUop=0, start 1 cycle -> next cycle ALUctrl='h2, done=1, stall=0; following cycle all 0.
//   2 R-type funct=0 (SLL), Shamt=11 -> ALUctrl C,B,A over 3 cycles;
//     feedback 0,1,1; stall 1,1,0; done 0,0,1.
//   3 SRL, Shamt=31 -> F,F,F,E,E,E,D (7 cycles); stall high for the first 6; done on the 7th.
//   4 funct='h19 (MULTU), MULT_CYCLES=4 -> 'h13 for 4 cycles; stall 1,1,1,0; done on the 4th.
//   5 SRA, Shamt=10: assert reset during step 2 -> next cycle all outputs 0, IDLE;
//     a later start with ALUop=5 yields 'h1.
//   6 start pulsed during an SLL Shamt=9 sequence -> ignored; sequence C,A completes unchanged.
//     SRA with Shamt=0 -> single cycle 'h0, done=1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU control decoder that sequences shifts into 8/2/1 steps and holds MULTU for MULT_CYCLES
module alu_seq_ctrl #(
   parameter int SHAMT_W     = 5,
   parameter int MULT_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [4:0]         ALUop,
   input  logic [5:0]         functionCode,
   input  logic [SHAMT_W-1:0] Shamt,
   output logic [5:0]         ALUctrl,
   output logic               feedback,
   output logic               stall,
   output logic               done
);
   localparam int MW = MULT_CYCLES > 1 ? $clog2(MULT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, MULT} state_t;
   state_t state, state_n;
   logic [SHAMT_W-4:0] r8, r8_n, a8, b8;
   logic [1:0] r2, r2_n, a2, b2, kind, kind_n, sk;
   logic r1, r1_n, a1, b1, s8, s2, last;
   logic [MW-1:0] mcnt, mcnt_n;
   logic [5:0] code, step_code, ctrl_n;
   logic fb_n, stall_n, done_n, is_shift, is_mult;
   always_comb begin
      code = 6'h0;
      case (ALUop)
         5'd0: code = 6'h2;
         5'd1: code = 6'h6;
         5'd2:
            case (functionCode)
               6'h20: code = 6'h2;
               6'h21: code = 6'h3;
               6'h23: code = 6'h6;
               6'h25: code = 6'h1;
               6'h26: code = 6'h4;
               6'h2A: code = 6'h7;
               6'h2B: code = 6'h8;
               6'h19: code = 6'h13;
               default: code = 6'h0;
            endcase
         5'd3: code = 6'h3;
         5'd5: code = 6'h1;
         5'd6: code = 6'h4;
         5'd7: code = 6'h7;
         5'd8: code = 6'h8;
         5'd9: code = 6'h9;
         default: code = 6'h0;
      endcase
   end
   assign is_shift = ALUop == 5'd2 && (functionCode == 6'h00 || functionCode == 6'h02 || functionCode == 6'h03) && Shamt != '0;
   assign is_mult  = ALUop == 5'd2 && functionCode == 6'h19 && MULT_CYCLES > 1;
   // One step picker serves both the accept edge (fresh Shamt) and later steps (remaining counts)
   assign a8 = state == SHIFT ? r8 : Shamt[SHAMT_W-1:3];
   assign a2 = state == SHIFT ? r2 : Shamt[2:1];
   assign a1 = state == SHIFT ? r1 : Shamt[0];
   assign sk = state == SHIFT ? kind : functionCode[1:0];
   assign s8 = a8 != '0;
   assign s2 = !s8 && a2 != 2'd0;
   assign b8 = a8 - (SHAMT_W-3)'(s8);
   assign b2 = a2 - 2'(s2);
   assign b1 = (s8 || s2) ? a1 : 1'b0;
   assign last = b8 == '0 && b2 == 2'd0 && !b1;
   assign step_code = (sk == 2'd0 ? 6'hA : sk == 2'd2 ? 6'hD : 6'h10) + (s8 ? 6'd2 : s2 ? 6'd1 : 6'd0);
   always_comb begin
      state_n = state;
      r8_n = r8;
      r2_n = r2;
      r1_n = r1;
      kind_n = kind;
      mcnt_n = mcnt;
      ctrl_n = 6'h0;
      fb_n = 1'b0;
      stall_n = 1'b0;
      done_n = 1'b0;
      case (state)
         IDLE:
            if (start) begin
               if (is_shift) begin
                  ctrl_n = step_code;
                  stall_n = !last;
                  done_n = last;
                  {r8_n, r2_n, r1_n} = {b8, b2, b1};
                  kind_n = sk;
                  state_n = last ? IDLE : SHIFT;
               end else if (is_mult) begin
                  ctrl_n = 6'h13;
                  stall_n = 1'b1;
                  mcnt_n = MW'(MULT_CYCLES - 1);
                  state_n = MULT;
               end else begin
                  ctrl_n = code;
                  done_n = 1'b1;
               end
            end
         SHIFT: begin
            ctrl_n = step_code;
            fb_n = 1'b1;
            stall_n = !last;
            done_n = last;
            {r8_n, r2_n, r1_n} = {b8, b2, b1};
            state_n = last ? IDLE : SHIFT;
         end
         MULT: begin
            ctrl_n = 6'h13;
            stall_n = mcnt != MW'(1);
            done_n = mcnt == MW'(1);
            mcnt_n = mcnt - MW'(1);
            state_n = mcnt == MW'(1) ? IDLE : MULT;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         r8 <= '0;
         r2 <= 2'd0;
         r1 <= 1'b0;
         kind <= 2'd0;
         mcnt <= '0;
         ALUctrl <= 6'h0;
         feedback <= 1'b0;
         stall <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         r8 <= r8_n;
         r2 <= r2_n;
         r1 <= r1_n;
         kind <= kind_n;
         mcnt <= mcnt_n;
         ALUctrl <= ctrl_n;
         feedback <= fb_n;
         stall <= stall_n;
         done <= done_n;
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and random checks of alu_seq_ctrl against a queue-based expected-output model
module tb_alu_seq_ctrl;
   localparam int SW = 5, MC = 4;
   logic clk = 0, reset = 1, start = 0;
   logic [4:0] ALUop = 0;
   logic [5:0] functionCode = 0;
   logic [SW-1:0] Shamt = 0;
   logic [5:0] ALUctrl;
   logic feedback, stall, done;
   int checks = 0, passes = 0;
   bit chk_en = 0;
   logic [8:0] q[$];
   logic [8:0] exp_o = 9'd0;
   logic [5:0] op_tab [0:9] = '{6'h2, 6'h6, 6'h0, 6'h3, 6'h0, 6'h1, 6'h4, 6'h7, 6'h8, 6'h9};
   logic [5:0] fl [0:13] = '{6'h00, 6'h02, 6'h03, 6'h19, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h10, 6'h12};

   alu_seq_ctrl #(.SHAMT_W(SW), .MULT_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUop(ALUop), .functionCode(functionCode),
      .Shamt(Shamt), .ALUctrl(ALUctrl), .feedback(feedback), .stall(stall), .done(done));

   always #5 clk = ~clk;

   function automatic logic [5:0] rcode(logic [5:0] f);
      case (f)
         6'h20: return 6'h2;
         6'h21: return 6'h3;
         6'h23: return 6'h6;
         6'h25: return 6'h1;
         6'h26: return 6'h4;
         6'h2A: return 6'h7;
         6'h2B: return 6'h8;
         6'h19: return 6'h13;
         default: return 6'h0;
      endcase
   endfunction

   function automatic logic [5:0] scode(logic [5:0] f, int amt);
      if (f == 6'h00) return amt == 8 ? 6'hC : amt == 2 ? 6'hB : 6'hA;
      if (f == 6'h02) return amt == 8 ? 6'hF : amt == 2 ? 6'hE : 6'hD;
      return amt == 8 ? 6'h12 : amt == 2 ? 6'h11 : 6'h10;
   endfunction

   task automatic accept();
      logic [5:0] steps[$];
      int amt = int'(Shamt);
      if (ALUop == 5'd2 && (functionCode == 6'h00 || functionCode == 6'h02 || functionCode == 6'h03) && amt != 0) begin
         for (int i = 0; i < amt / 8; i++) steps.push_back(scode(functionCode, 8));
         for (int i = 0; i < (amt % 8) / 2; i++) steps.push_back(scode(functionCode, 2));
         if (amt % 2 == 1) steps.push_back(scode(functionCode, 1));
         foreach (steps[i])
            q.push_back({steps[i], 1'(i > 0), 1'(i < steps.size() - 1), 1'(i == steps.size() - 1)});
      end else if (ALUop == 5'd2 && functionCode == 6'h19 && MC > 1) begin
         for (int c = 0; c < MC; c++) q.push_back({6'h13, 1'b0, 1'(c < MC - 1), 1'(c == MC - 1)});
      end else begin
         q.push_back({ALUop == 5'd2 ? rcode(functionCode) : ALUop < 5'd10 ? op_tab[ALUop] : 6'h0, 3'b001});
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         exp_o <= 9'd0;
      end else begin
         if (q.size() == 0 && start) accept();
         exp_o <= q.size() != 0 ? q.pop_front() : 9'd0;
      end
   end

   task automatic check(string name, logic [8:0] act, logic [8:0] want);
      checks++;
      if (act === want) passes++;
      else $display("FAIL %s: ctrl/fb/stall/done got %h/%b/%b/%b want %h/%b/%b/%b",
                    name, act[8:3], act[2], act[1], act[0], want[8:3], want[2], want[1], want[0]);
   endtask

   always @(negedge clk) if (chk_en) check("cycle", {ALUctrl, feedback, stall, done}, exp_o);

   task automatic lit(string name, logic [8:0] want);
      @(negedge clk);
      #1 check(name, {ALUctrl, feedback, stall, done}, want);
   endtask

   task automatic go(logic [4:0] op, logic [5:0] f, logic [SW-1:0] sh);
      ALUop = op;
      functionCode = f;
      Shamt = sh;
      start = 1;
      @(posedge clk);
      #2 start = 0;
   endtask

   initial begin
      @(posedge clk);
      #1 chk_en = 1;
      lit("reset", 9'd0);
      @(posedge clk);
      #2 reset = 0;
      go(5'd0, 6'h0, 0);
      lit("t1_add", {6'h2, 3'b001});
      lit("t1_idle", 9'd0);
      go(5'd2, 6'h00, 11);
      lit("t2_s1", {6'hC, 3'b010});
      lit("t2_s2", {6'hB, 3'b110});
      lit("t2_s3", {6'hA, 3'b101});
      go(5'd2, 6'h02, 31);
      for (int i = 0; i < 7; i++)
         lit("t3_srl", {i < 3 ? 6'hF : i < 6 ? 6'hE : 6'hD, 1'(i > 0), 1'(i < 6), 1'(i == 6)});
      go(5'd2, 6'h19, 0);
      for (int i = 0; i < 4; i++) lit("t4_mult", {6'h13, 1'b0, 1'(i < 3), 1'(i == 3)});
      go(5'd2, 6'h03, 10);
      lit("t5_s1", {6'h12, 3'b010});
      @(posedge clk);
      #1 reset = 1;
      lit("t5_s2", {6'h11, 3'b101});
      lit("t5_rst", 9'd0);
      #1 reset = 0;
      go(5'd5, 6'h0, 0);
      lit("t5_or", {6'h1, 3'b001});
      go(5'd2, 6'h00, 9);
      lit("t6_s1", {6'hC, 3'b010});
      ALUop = 5'd0;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      lit("t6_s2", {6'hA, 3'b101});
      lit("t6_idle", 9'd0);
      go(5'd2, 6'h03, 0);
      lit("t6_sra0", {6'h0, 3'b001});
      repeat (3000) begin
         @(posedge clk);
         #2;
         if (q.size() == 0) begin
            ALUop = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'd2;
            functionCode = $urandom_range(0, 7) == 0 ? 6'($urandom_range(0, 63)) : fl[$urandom_range(0, 13)];
            Shamt = SW'($urandom_range(0, 31));
         end
         start = 1'($urandom_range(0, 1));
         reset = $urandom_range(0, 49) == 0;
      end
      #1 reset = 0;
      start = 0;
      repeat (3) @(posedge clk);
      #6;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
